// File: rtl/dds_sweep_pkg.sv
// Shared types and defaults for the DDS frequency-sweep sequencer.
// The triangle sweep is enabled by defining DDS_SWEEP_TRI_EN.
package dds_sweep_pkg;

  localparam int FTW_W_DEF   = 32;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_STEP  = 2'd3
  } sweep_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire is high in the last cycle of a dwell.
// A dwell of 0 behaves as 1.
module dds_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] cnt_r;
  logic               active_r;

  assign expire = active_r && (cnt_r == CNT_ZERO);

  // Counter runs from max(dwell,1)-1 down to zero, then idles until reloaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= CNT_ZERO;
      active_r <= 1'b0;
    end else if (clear) begin
      active_r <= 1'b0;
    end else if (load) begin
      active_r <= 1'b1;
      cnt_r    <= (dwell == CNT_ZERO) ? CNT_ZERO : (dwell - CNT_ONE);
    end else if (expire) begin
      active_r <= 1'b0;
    end else if (active_r) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS tuning word and phase clear.
// Define DDS_SWEEP_TRI_EN to build the up/down (triangle) sweep.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int FTW_W   = FTW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
  input  logic               cfg_tri,
  input  logic               start,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               ftw_upd,
  output logic               phase_clr,
  output logic               busy,
  output logic               done
);

  localparam logic [FTW_W-1:0] FTW_ZERO = {FTW_W{1'b0}};
  localparam logic [FTW_W-1:0] FTW_ONE  = {{(FTW_W-1){1'b0}}, 1'b1};

  sweep_state_e       state_r, state_s;
  logic [FTW_W-1:0]   ftw_r, ftw_s;
  logic               upd_r, upd_s, clr_r, clr_s;
  logic               busy_r, busy_s, done_r, done_s, ready_r, ready_s;
  logic [FTW_W-1:0]   start_r, stop_r, step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               cont_r;
  logic               tmr_load_s, tmr_clear_s, tmr_expire_s;
  logic [FTW_W-1:0]   step_eff_s, up_next_s, nxt_s;
  logic [FTW_W:0]     up_sum_s;
  logic               fin_s;

  assign step_eff_s = (step_r == FTW_ZERO) ? FTW_ONE : step_r;
  assign up_sum_s   = {1'b0, ftw_r} + {1'b0, step_eff_s};
  assign up_next_s  = (up_sum_s[FTW_W] || (up_sum_s[FTW_W-1:0] >= stop_r)) ?
                      stop_r : up_sum_s[FTW_W-1:0];

`ifdef DDS_SWEEP_TRI_EN
  logic             tri_r;
  logic             dir_r, dir_s;
  logic [FTW_W:0]   dn_diff_s;
  logic [FTW_W-1:0] dn_next_s;

  // A borrow shows up as the extra top bit of the widened difference
  assign dn_diff_s = {1'b0, ftw_r} - {1'b0, step_eff_s};
  assign dn_next_s = (dn_diff_s[FTW_W] || (dn_diff_s[FTW_W-1:0] <= start_r)) ?
                     start_r : dn_diff_s[FTW_W-1:0];
`else
  logic unused_tri_s;
  assign unused_tri_s = cfg_tri;
`endif

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load_s),
    .clear  (tmr_clear_s),
    .dwell  (dwell_r),
    .expire (tmr_expire_s)
  );

  // Next-state and next-output decode; the step decision happens at dwell expiry
  always_comb begin
    state_s     = state_r;
    ftw_s       = ftw_r;
    upd_s       = 1'b0;
    clr_s       = 1'b0;
    busy_s      = busy_r;
    done_s      = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_clear_s = 1'b0;
    fin_s       = 1'b0;
    nxt_s       = up_next_s;
`ifdef DDS_SWEEP_TRI_EN
    dir_s       = dir_r;
`endif
    if (abort) begin
      state_s     = ST_IDLE;
      busy_s      = 1'b0;
      tmr_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s    = ST_LOAD;
            ftw_s      = start_r;
            upd_s      = 1'b1;
            clr_s      = 1'b1;
            busy_s     = 1'b1;
            tmr_load_s = 1'b1;
`ifdef DDS_SWEEP_TRI_EN
            dir_s      = DIR_UP;
`endif
          end else begin
            busy_s = 1'b0;
          end
        end
        ST_LOAD, ST_DWELL, ST_STEP: begin
          if (tmr_expire_s) begin
`ifdef DDS_SWEEP_TRI_EN
            if (dir_r == DIR_UP) begin
              if (ftw_r >= stop_r) begin
                if (tri_r && (start_r < stop_r)) begin
                  dir_s = DIR_DOWN;
                  nxt_s = dn_next_s;
                end else begin
                  fin_s = 1'b1;
                end
              end else begin
                nxt_s = up_next_s;
              end
            end else begin
              if (ftw_r <= start_r) begin
                if (cont_r) begin
                  dir_s = DIR_UP;
                  nxt_s = up_next_s;
                end else begin
                  fin_s = 1'b1;
                end
              end else begin
                nxt_s = dn_next_s;
              end
            end
`else
            fin_s = (ftw_r >= stop_r);
`endif
            if (fin_s && cont_r) begin
              state_s    = ST_LOAD;
              ftw_s      = start_r;
              upd_s      = 1'b1;
              clr_s      = 1'b1;
              tmr_load_s = 1'b1;
`ifdef DDS_SWEEP_TRI_EN
              dir_s      = DIR_UP;
`endif
            end else if (fin_s) begin
              state_s = ST_IDLE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              state_s    = ST_STEP;
              ftw_s      = nxt_s;
              upd_s      = 1'b1;
              tmr_load_s = 1'b1;
            end
          end else begin
            state_s = ST_DWELL;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          busy_s      = 1'b0;
          tmr_clear_s = 1'b1;
        end
      endcase
    end
    ready_s = (state_s == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ftw_r   <= FTW_ZERO;
      upd_r   <= 1'b0;
      clr_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
`ifdef DDS_SWEEP_TRI_EN
      dir_r   <= DIR_UP;
`endif
    end else begin
      state_r <= state_s;
      ftw_r   <= ftw_s;
      upd_r   <= upd_s;
      clr_r   <= clr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
`ifdef DDS_SWEEP_TRI_EN
      dir_r   <= dir_s;
`endif
    end
  end

  // Shadow configuration, writable only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_r <= FTW_ZERO;
      stop_r  <= FTW_ZERO;
      step_r  <= FTW_ZERO;
      dwell_r <= {DWELL_W{1'b0}};
      cont_r  <= 1'b0;
`ifdef DDS_SWEEP_TRI_EN
      tri_r   <= 1'b0;
`endif
    end else if (cfg_valid && ready_r) begin
      start_r <= cfg_start_ftw;
      stop_r  <= cfg_stop_ftw;
      step_r  <= cfg_step;
      dwell_r <= cfg_dwell;
      cont_r  <= cfg_cont;
`ifdef DDS_SWEEP_TRI_EN
      tri_r   <= cfg_tri;
`endif
    end
  end

  assign ftw_out   = ftw_r;
  assign ftw_upd   = upd_r;
  assign phase_clr = clr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_ready = ready_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus random
// one-shot sweeps compared against a word-list model of the sweep.
module tb_dds_sweep_ctrl;

`ifdef DDS_SWEEP_TRI_EN
  localparam bit TRI_BUILD = 1'b1;
`else
  localparam bit TRI_BUILD = 1'b0;
`endif

  logic        clk, reset, cfg_valid, cfg_ready, cfg_cont, cfg_tri, start, abort;
  logic [31:0] cfg_start_ftw, cfg_stop_ftw, cfg_step, ftw_out;
  logic [15:0] cfg_dwell;
  logic        ftw_upd, phase_clr, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ftw;
    logic        upd;
    logic        clr;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  dds_sweep_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_ftw(cfg_start_ftw), .cfg_stop_ftw(cfg_stop_ftw), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont), .cfg_tri(cfg_tri),
    .start(start), .abort(abort), .ftw_out(ftw_out), .ftw_upd(ftw_upd),
    .phase_clr(phase_clr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list the tuning words of one pass, then expand them into cycles.
  task automatic model_sweep(input logic [31:0] st, input logic [31:0] sp,
                             input logic [31:0] stp, input logic [15:0] dw,
                             input bit cont, input bit tri_on, input int max_cyc);
    longint wq[$];
    longint s, d, w, lo, hi;
    int     k;
    bit     first, tri_loop;
    exp_t   e;
    lo = longint'(st);
    hi = longint'(sp);
    s  = (stp == 32'd0) ? 64'sd1 : longint'(stp);
    d  = (dw == 16'd0) ? 64'sd1 : longint'(dw);
    tri_loop = tri_on && (lo < hi);
    exp_q.delete();
    w = lo;
    wq.push_back(w);
    while (w < hi) begin
      w = (w + s >= hi) ? hi : w + s;
      wq.push_back(w);
    end
    if (tri_loop) begin
      while (w > lo) begin
        w = (w - s <= lo) ? lo : w - s;
        wq.push_back(w);
      end
    end
    k = 0;
    first = 1'b1;
    while (1) begin
      for (longint c = 0; c < d; c++) begin
        e.ftw  = wq[k][31:0];
        e.upd  = (c == 0);
        e.clr  = (c == 0) && (k == 0) && (first || !tri_loop);
        e.busy = 1'b1;
        e.done = 1'b0;
        exp_q.push_back(e);
      end
      k++;
      if (k == wq.size()) begin
        if (!cont) begin
          e.ftw = wq[wq.size()-1][31:0];
          e.upd = 1'b0; e.clr = 1'b0; e.busy = 1'b0; e.done = 1'b1;
          exp_q.push_back(e);
          e.done = 1'b0;
          exp_q.push_back(e);
          break;
        end
        k = tri_loop ? 1 : 0;
        first = 1'b0;
      end
      if (cont && (exp_q.size() >= max_cyc)) break;
    end
  endtask

  task automatic apply_cfg(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                           input logic [15:0] dw, input bit cont, input bit tri_in);
    @(negedge clk);
    cfg_start_ftw = st; cfg_stop_ftw = sp; cfg_step = stp;
    cfg_dwell = dw; cfg_cont = cont; cfg_tri = tri_in; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !== {32'd0, 5'b00001}) begin
      errors++;
      $display("FAIL reset: got ftw=%h upd=%b clr=%b busy=%b done=%b rdy=%b, expected 0/0/0/0/0/1",
               ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready);
    end
    reset = 1'b0;
    // Zeroed shadow config: a start gives a single word 0 for one cycle, then done
    model_sweep(32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 0);
    pulse_start();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !==
          {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done, ~exp_q[i].busy}) begin
        errors++;
        $display("FAIL reset_shadow cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                 i + 1, ftw_out, ftw_upd, phase_clr, busy, done,
                 exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
      end
    end
  endtask

  task automatic test_oneshot(input string name, input logic [31:0] st, input logic [31:0] sp,
                              input logic [31:0] stp, input logic [15:0] dw, input bit tri_in);
    apply_cfg(st, sp, stp, dw, 1'b0, tri_in);
    model_sweep(st, sp, stp, dw, 1'b0, tri_in && TRI_BUILD, 0);
    pulse_start();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !==
          {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done, ~exp_q[i].busy}) begin
        errors++;
        $display("FAIL %s cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b r=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                 name, i + 1, ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready,
                 exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] base, st, sp, stp;
    logic [15:0] dw;
    bit          tri_in;
    for (int n = 0; n < 12; n++) begin
      base   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FE00 : 32'd0;
      st     = base + 32'($urandom_range(0, 200));
      sp     = base + 32'($urandom_range(0, 511));
      stp    = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0) stp = 32'h0000_0300;
      dw     = 16'($urandom_range(0, 3));
      tri_in = 1'($urandom_range(0, 1));
      apply_cfg(st, sp, stp, dw, 1'b0, tri_in);
      model_sweep(st, sp, stp, dw, 1'b0, tri_in && TRI_BUILD, 0);
      pulse_start();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !==
            {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done, ~exp_q[i].busy}) begin
          errors++;
          $display("FAIL random#%0d cyc %0d (st=%h sp=%h stp=%h dw=%0d tri=%b): got ftw=%h u=%b c=%b b=%b d=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                   n, i + 1, st, sp, stp, dw, tri_in, ftw_out, ftw_upd, phase_clr, busy, done,
                   exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
        end
      end
    end
  endtask

  task automatic test_abort();
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd4, 1'b0, 1'b0);
    model_sweep(32'd100, 32'd130, 32'd10, 16'd4, 1'b0, 1'b0, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done} !==
          {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done}) begin
        errors++;
        $display("FAIL abort_pre cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                 i + 1, ftw_out, ftw_upd, phase_clr, busy, done,
                 exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !== {32'd110, 5'b00001}) begin
        errors++;
        $display("FAIL abort_post cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b r=%b, expected ftw=6e u=0 c=0 b=0 d=0 r=1",
                 i, ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready);
      end
    end
    // abort together with start keeps the block idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !== {32'd110, 5'b00001}) begin
        errors++;
        $display("FAIL abort_start cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b r=%b, expected ftw=6e idle",
                 i, ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready);
      end
    end
  endtask

  task automatic test_continuous();
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd4, 1'b1, 1'b0);
    model_sweep(32'd100, 32'd130, 32'd10, 16'd4, 1'b1, 1'b0, 40);
    pulse_start();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !==
          {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done, ~exp_q[i].busy}) begin
        errors++;
        $display("FAIL continuous cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                 i + 1, ftw_out, ftw_upd, phase_clr, busy, done,
                 exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL continuous_abort: got busy=%b done=%b rdy=%b, expected 0/0/1", busy, done, cfg_ready);
    end
  endtask

  task automatic test_cfg_locked();
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd1, 1'b0, 1'b0);
    model_sweep(32'd100, 32'd130, 32'd10, 16'd1, 1'b0, 1'b0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if ({ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready} !==
            {exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done, ~exp_q[i].busy}) begin
          errors++;
          $display("FAIL cfg_locked pass %0d cyc %0d: got ftw=%h u=%b c=%b b=%b d=%b r=%b, expected ftw=%h u=%b c=%b b=%b d=%b",
                   pass, i + 1, ftw_out, ftw_upd, phase_clr, busy, done, cfg_ready,
                   exp_q[i].ftw, exp_q[i].upd, exp_q[i].clr, exp_q[i].busy, exp_q[i].done);
        end
        // Offer a different config while busy; it must not be taken
        if (pass == 0 && i == 1) begin
          cfg_start_ftw = 32'd5000; cfg_stop_ftw = 32'd9000; cfg_step = 32'd7;
          cfg_dwell = 16'd3; cfg_valid = 1'b1;
        end else begin
          cfg_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_cont = 1'b0; cfg_tri = 1'b0;
    start = 1'b0; abort = 1'b0;
    cfg_start_ftw = 32'd0; cfg_stop_ftw = 32'd0; cfg_step = 32'd0; cfg_dwell = 16'd0;
    test_reset();
    test_oneshot("plan", 32'd100, 32'd130, 32'd10, 16'd4, 1'b0);
    test_oneshot("clamp", 32'd100, 32'd125, 32'd10, 16'd1, 1'b0);
    test_oneshot("overflow", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0020, 16'd2, 1'b0);
    test_oneshot("start_ge_stop", 32'd300, 32'd200, 32'd5, 16'd3, 1'b0);
    test_oneshot("triangle", 32'd100, 32'd120, 32'd10, 16'd2, 1'b1);
    test_abort();
    test_continuous();
    test_cfg_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
